// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared state encoding and defaults for the boot loader.
// Rev 1.0. Optional feature macro: BOOT_CHECKSUM_EN (adds the CSUM state).
`default_nettype none

package imem_boot_loader_pkg;

  localparam logic [7:0] c_SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    S_WAIT_SYNC = 3'd0,
    S_LEN_HI    = 3'd1,
    S_LEN_LO    = 3'd2,
    S_DATA_HI   = 3'd3,
    S_DATA_LO   = 3'd4,
`ifdef BOOT_CHECKSUM_EN
    S_CSUM      = 3'd5,
`endif
    S_DONE      = 3'd6,
    S_ERR       = 3'd7
  } boot_state_e;

  // The inter-byte timeout only runs while a frame is in progress.
  function automatic logic f_timer_active(input boot_state_e s);
    return !((s == S_WAIT_SYNC) || (s == S_DONE) || (s == S_ERR));
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_boot_loader_timer.sv
// imem_boot_loader_timer: loadable down-counter for the inter-byte timeout.
// Rev 1.0. Clear reloads TIMEOUT_CYCLES; expired is high once the count reaches zero.
`default_nettype none

module imem_boot_loader_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_200_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int c_CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= c_CW'(TIMEOUT_CYCLES);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_CW'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: writes a UART byte-stream image into i_ram and releases the CPU on success.
// Rev 1.0. Optional feature macro: BOOT_CHECKSUM_EN (trailing 8-bit sum byte checked).
`default_nettype none

module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter logic [7:0]  SYNC_BYTE      = c_SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_200_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_boot_req,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic [15:0]       o_din,
  output logic              o_w_en,
  output logic              o_cpu_hold,
  output logic              o_boot_done,
  output logic              o_boot_err
);

  localparam logic [16:0] c_MAX_WORDS = 17'(1) << ADDR_W;

  boot_state_e       r_state;
  logic [7:0]        r_byte_hi;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_last;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic        w_active;
  logic        w_expired;
  logic        w_tmr_clr;
  logic [15:0] w_len;
  logic        w_len_ok;

  assign w_active  = f_timer_active(r_state);
  assign w_tmr_clr = i_rx_valid || i_boot_req || !w_active;
  assign w_len     = {r_byte_hi, i_rx_data};
  assign w_len_ok  = (w_len != 16'd0) && ({1'b0, w_len} <= c_MAX_WORDS);

  imem_boot_loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_tmr_clr),
    .i_en     (w_active),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_WAIT_SYNC;
      r_byte_hi   <= 8'd0;
      r_idx       <= '0;
      r_last      <= '0;
`ifdef BOOT_CHECKSUM_EN
      r_csum      <= 8'd0;
`endif
      o_w_addr    <= '0;
      o_din       <= 16'd0;
      o_w_en      <= 1'b0;
      o_cpu_hold  <= 1'b1;
      o_boot_done <= 1'b0;
      o_boot_err  <= 1'b0;
    end else begin
      o_w_en <= 1'b0;
      // boot_req outranks everything, including a byte arriving the same cycle.
      if (i_boot_req) begin
        r_state     <= S_WAIT_SYNC;
        o_cpu_hold  <= 1'b1;
        o_boot_done <= 1'b0;
        o_boot_err  <= 1'b0;
      end else if (w_active && w_expired) begin
        r_state     <= S_ERR;
        o_cpu_hold  <= 1'b1;
        o_boot_done <= 1'b0;
        o_boot_err  <= 1'b1;
      end else if (i_rx_valid) begin
        case (r_state)
          S_WAIT_SYNC: begin
            if (i_rx_data == SYNC_BYTE) begin
              r_state <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            r_byte_hi <= i_rx_data;
            r_state   <= S_LEN_LO;
          end
          S_LEN_LO: begin
            if (w_len_ok) begin
              r_idx   <= '0;
              r_last  <= ADDR_W'(w_len - 16'd1);
`ifdef BOOT_CHECKSUM_EN
              r_csum  <= 8'd0;
`endif
              r_state <= S_DATA_HI;
            end else begin
              r_state     <= S_ERR;
              o_cpu_hold  <= 1'b1;
              o_boot_done <= 1'b0;
              o_boot_err  <= 1'b1;
            end
          end
          S_DATA_HI: begin
            r_byte_hi <= i_rx_data;
`ifdef BOOT_CHECKSUM_EN
            r_csum    <= r_csum + i_rx_data;
`endif
            r_state   <= S_DATA_LO;
          end
          S_DATA_LO: begin
            o_w_en   <= 1'b1;
            o_din    <= {r_byte_hi, i_rx_data};
            o_w_addr <= r_idx;
            r_idx    <= r_idx + ADDR_W'(1);
`ifdef BOOT_CHECKSUM_EN
            r_csum   <= r_csum + i_rx_data;
`endif
            if (r_idx == r_last) begin
`ifdef BOOT_CHECKSUM_EN
              r_state <= S_CSUM;
`else
              r_state     <= S_DONE;
              o_cpu_hold  <= 1'b0;
              o_boot_done <= 1'b1;
              o_boot_err  <= 1'b0;
`endif
            end else begin
              r_state <= S_DATA_HI;
            end
          end
`ifdef BOOT_CHECKSUM_EN
          S_CSUM: begin
            if (i_rx_data == r_csum) begin
              r_state     <= S_DONE;
              o_cpu_hold  <= 1'b0;
              o_boot_done <= 1'b1;
              o_boot_err  <= 1'b0;
            end else begin
              r_state     <= S_ERR;
              o_cpu_hold  <= 1'b1;
              o_boot_done <= 1'b0;
              o_boot_err  <= 1'b1;
            end
          end
`endif
          S_DONE, S_ERR: begin
            r_state <= r_state;
          end
          default: begin
            r_state <= S_WAIT_SYNC;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
